spare_cfg_loader: RTL
=====================

Name: spare_cfg_loader

Overview:
- Serial configuration sequencer for the bank of ECO spare-cell select flops that sit beside the spare-cell macros.
- Takes a parallel CHAIN_LEN-bit configuration word from the housekeeping register file and shifts it MSB-first into the external select chain on a divided serial clock.
- Pulses a latch strobe so the spare cells switch atomically, then captures the chain's previous contents, shifted out during the load, as readback.

Parameters:
- CHAIN_LEN, 32, number of select flops in the external chain (≥2).
- CLK_DIV, 4, clk cycles per ser_clk half-period (≥1).
- CNT_W, $clog2(CHAIN_LEN), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset; asynchronous assert, active-low.
- cfg_data  input  CHAIN_LEN  configuration word; sampled only on an accepted start.
- start  input  1  load request; single-cycle or level.
- busy  output  1  high from acceptance until done.
- done  output  1  one-cycle pulse when the load completes.
- cfg_readback  output  CHAIN_LEN  previous chain contents; updated at done.
- ser_clk  output  1  divided shift clock to the chain.
- ser_dout  output  1  serial data to the chain head.
- ser_din  input  1  serial data from the chain tail.
- ser_latch  output  1  parallel-latch strobe to the spare-cell select latches.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset resetn is asynchronous and active-low.
- Reset values: busy=0, done=0, ser_clk=0, ser_dout=0, ser_latch=0, cfg_readback=0, state IDLE, counters 0.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE:
  - start=1 at edge T is accepted; cfg_data is copied to a shadow register.
  - Next state SHIFT_LO, bit index = CHAIN_LEN-1.
  - busy=1 from T+1.
- SHIFT_LO (CLK_DIV cycles):
  - ser_clk=0.
  - ser_dout = shadow[bit index], driven from the first cycle of the phase and stable for the whole phase.
  - On the last cycle of the phase, ser_din is sampled into readback shadow bit [bit index]; go to SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles):
  - ser_clk=1; ser_dout is held.
  - At phase end: if bit index=0, go to LATCH; else decrement the index and go to SHIFT_LO.
- LATCH (CLK_DIV cycles):
  - ser_clk=0, ser_latch=1, ser_dout=0.
  - Then go to DONE.
- DONE (1 cycle):
  - done=1, busy=0, ser_latch=0.
  - cfg_readback is loaded from the readback shadow; next state IDLE.
- Latency: done is asserted at edge T + 2·CLK_DIV·CHAIN_LEN + CLK_DIV + 1.
- start during busy or DONE is ignored; no queuing.
- A level-held start re-triggers in the cycle after DONE.
- cfg_data changes during busy have no effect.
- The phase counter wraps from CLK_DIV-1 to 0. For CLK_DIV=1 every phase lasts exactly one cycle.
- Reset mid-operation: all outputs return to reset values immediately and ser_latch is never asserted. The spare-cell latches therefore keep their previous configuration; a partially shifted chain is acceptable.
- All outputs are registered; there is no combinational path from input to output.

Decomposition:
- Shared package spare_cfg_pkg holds:
  - the state enum (IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE);
  - default constants SPARE_CHAIN_LEN=32 and SPARE_CLK_DIV=4.
- One sub-module, spare_cfg_phase_cnt:
  - CLK_DIV-modulo counter with clear input and terminal-count output;
  - used by SHIFT_LO, SHIFT_HI and LATCH.

Test Plan (CHAIN_LEN=8, CLK_DIV=2 unless stated):
- Reset then idle: no start → all outputs 0 for 50 cycles. Start at T with cfg_data=8'hA5 → ser_dout sequence 1,0,1,0,0,1,0,1 sampled on ser_clk rising edges; 8 rising edges total; ser_latch high for exactly 2 cycles; done pulse at T+35.
- Readback: behavioural 8-bit chain model preloaded with 8'h3C, load 8'hA5 → cfg_readback=8'h3C at done. A second load of 8'h00 → cfg_readback=8'hA5.
- Start while busy: pulse start at T+10 with cfg_data=8'hFF → ignored; chain receives 8'hA5; exactly one done pulse.
- Held start: start tied high with cfg_data=8'h81 → back-to-back loads, second acceptance in the cycle after done, busy low for exactly that one DONE cycle.
- Reset mid-shift: deassert resetn at T+12 → outputs 0 asynchronously, no ser_latch pulse, chain model's latched value unchanged. After reset release, a new load of 8'h5A completes normally.
- CLK_DIV=1, CHAIN_LEN=32, cfg_data=32'hDEADBEEF → ser_clk toggles every cycle; done at T+66; chain model latches 32'hDEADBEEF.

Source files
------------

// File: rtl/spare_cfg_pkg.sv
// Shared types and default sizing for the spare-cell select-chain loader.
package spare_cfg_pkg;

    localparam int unsigned SPARE_CHAIN_LEN = 32;
    localparam int unsigned SPARE_CLK_DIV   = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH    = 3'd3,
        DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/spare_cfg_phase_cnt.sv
// CLK_DIV-modulo phase counter; tc_c marks the last cycle of a serial clock phase.
module spare_cfg_phase_cnt
    import spare_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPARE_CLK_DIV
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    output logic tc_c
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] cnt_q, cnt_d;

    assign tc_c = (cnt_q == PW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tc_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spare_cfg_loader.sv
// Shifts a parallel config word MSB-first into the external spare-cell select chain,
// strobes the latches, and returns the chain's previous contents as readback.
module spare_cfg_loader
    import spare_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = SPARE_CHAIN_LEN,
    parameter int unsigned CLK_DIV   = SPARE_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [CHAIN_LEN-1:0] cfg_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] cfg_readback,
    output logic                 ser_clk,
    output logic                 ser_dout,
    input  logic                 ser_din,
    output logic                 ser_latch
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
    logic [CHAIN_LEN-1:0] rb_shadow_q, rb_shadow_d;
    logic [CHAIN_LEN-1:0] cfg_readback_q, cfg_readback_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ser_clk_q, ser_clk_d;
    logic                 ser_dout_q, ser_dout_d;
    logic                 ser_latch_q, ser_latch_d;
    logic                 phase_tc_c;
    logic                 phase_clr_c;

    // Counter only runs while a timed phase is active, so every phase starts at zero.
    assign phase_clr_c = (state_q == IDLE) || (state_q == DONE);

    spare_cfg_phase_cnt #(
        .CLK_DIV(CLK_DIV)
    ) u_phase_cnt (
        .clk   (clk),
        .resetn(resetn),
        .clr   (phase_clr_c),
        .tc_c  (phase_tc_c)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start)      state_d = SHIFT_LO;
            SHIFT_LO: if (phase_tc_c) state_d = SHIFT_HI;
            SHIFT_HI: if (phase_tc_c) state_d = (idx_q == '0) ? LATCH : SHIFT_LO;
            LATCH:    if (phase_tc_c) state_d = DONE;
            DONE:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Datapath and registered-output decode; busy rises with acceptance so it only drops for DONE.
    always_comb begin
        idx_d          = idx_q;
        shadow_d       = shadow_q;
        rb_shadow_d    = rb_shadow_q;
        cfg_readback_d = cfg_readback_q;
        busy_d         = 1'b0;
        done_d         = 1'b0;
        ser_clk_d      = 1'b0;
        ser_dout_d     = 1'b0;
        ser_latch_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = cfg_data;
                    idx_d    = CNT_W'(CHAIN_LEN - 1);
                    busy_d   = 1'b1;
                end
            end
            SHIFT_LO: begin
                busy_d     = 1'b1;
                ser_dout_d = shadow_q[idx_q];
                if (phase_tc_c) begin
                    rb_shadow_d[idx_q] = ser_din;
                end
            end
            SHIFT_HI: begin
                busy_d     = 1'b1;
                ser_clk_d  = 1'b1;
                ser_dout_d = shadow_q[idx_q];
                if (phase_tc_c && (idx_q != '0)) begin
                    idx_d = idx_q - CNT_W'(1);
                end
            end
            LATCH: begin
                busy_d      = 1'b1;
                ser_latch_d = 1'b1;
            end
            DONE: begin
                done_d         = 1'b1;
                cfg_readback_d = rb_shadow_q;
            end
            default: begin
                idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q          <= '0;
            shadow_q       <= '0;
            rb_shadow_q    <= '0;
            cfg_readback_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            ser_clk_q      <= 1'b0;
            ser_dout_q     <= 1'b0;
            ser_latch_q    <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            rb_shadow_q    <= rb_shadow_d;
            cfg_readback_q <= cfg_readback_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            ser_clk_q      <= ser_clk_d;
            ser_dout_q     <= ser_dout_d;
            ser_latch_q    <= ser_latch_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_readback = cfg_readback_q;
    assign ser_clk      = ser_clk_q;
    assign ser_dout     = ser_dout_q;
    assign ser_latch    = ser_latch_q;

endmodule
